// File: rtl/cdb_arbiter_if.sv
// Common Data Bus request/broadcast bundle between the functional units and the CDB arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned N_UNITS = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned CNT_W   = 16
);

    // Unit-side requests: result and RS tag per unit, flattened by unit index.
    logic [N_UNITS-1:0]        rts;
    logic [N_UNITS*DATA_W-1:0] req_data;
    logic [N_UNITS*TAG_W-1:0]  req_source;

    // Registered broadcast and status from the arbiter.
    logic [N_UNITS-1:0]        xmit;
    logic                      CDB_write;
    logic [DATA_W-1:0]         CDB_data;
    logic [TAG_W-1:0]          CDB_source;
    logic [CNT_W-1:0]          conflicts;
    logic                      tag_error;

    // Functional-unit side.
    modport master (
        output rts, req_data, req_source,
        input  xmit, CDB_write, CDB_data, CDB_source, conflicts, tag_error
    );

    // Arbiter side.
    modport slave (
        input  rts, req_data, req_source,
        output xmit, CDB_write, CDB_data, CDB_source, conflicts, tag_error
    );

endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter with registered broadcast, conflict counter
// and sticky invalid-tag flag.
module cdb_arbiter #(
    parameter int unsigned N_UNITS = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned CNT_W   = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    cdb_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    logic [N_UNITS-1:0] xmit_q,       xmit_d;
    logic               cdb_write_q,  cdb_write_d;
    logic [DATA_W-1:0]  cdb_data_q,   cdb_data_d;
    logic [TAG_W-1:0]   cdb_source_q, cdb_source_d;
    logic [CNT_W-1:0]   conflicts_q,  conflicts_d;
    logic               tag_error_q,  tag_error_d;
    logic [PTR_W-1:0]   ptr_q,        ptr_d;

    logic [N_UNITS-1:0] src_valid_c;
    logic [N_UNITS-1:0] eligible_c;
    logic               multi_c;
    logic               any_c;
    logic [PTR_W-1:0]   win_c;
    logic [PTR_W-1:0]   idx_c;

    // Eligibility: requesting, not granted last edge (blocks a double grant), valid tag.
    always_comb begin
        src_valid_c = '0;
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            src_valid_c[i] = (bus.req_source[i*TAG_W +: TAG_W] != '0);
        end
        eligible_c = bus.rts & ~xmit_q & src_valid_c;
        multi_c    = |(eligible_c & (eligible_c - N_UNITS'(1)));
    end

    // First eligible unit at or after the pointer, wrapping past the top index.
    always_comb begin
        any_c = 1'b0;
        win_c = '0;
        idx_c = '0;
        for (int unsigned k = 0; k < N_UNITS; k++) begin
            idx_c = PTR_W'((32'(ptr_q) + k) % N_UNITS);
            if (!any_c && eligible_c[idx_c]) begin
                any_c = 1'b1;
                win_c = idx_c;
            end
        end
    end

    // Next broadcast, pointer advance, saturating conflict count and sticky tag error.
    always_comb begin
        xmit_d       = '0;
        cdb_write_d  = 1'b0;
        cdb_data_d   = cdb_data_q;
        cdb_source_d = cdb_source_q;
        ptr_d        = ptr_q;
        conflicts_d  = conflicts_q;
        tag_error_d  = tag_error_q | (|(bus.rts & ~src_valid_c));

        if (any_c) begin
            xmit_d       = N_UNITS'(1) << win_c;
            cdb_write_d  = 1'b1;
            cdb_data_d   = bus.req_data[32'(win_c)*DATA_W +: DATA_W];
            cdb_source_d = bus.req_source[32'(win_c)*TAG_W +: TAG_W];
            ptr_d        = (win_c == PTR_W'(N_UNITS - 1)) ? '0 : win_c + PTR_W'(1);
        end

        if (multi_c && (conflicts_q != {CNT_W{1'b1}})) begin
            conflicts_d = conflicts_q + CNT_W'(1);
        end
    end

    // State registers; reset drops the broadcast immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xmit_q       <= '0;
            cdb_write_q  <= 1'b0;
            cdb_data_q   <= '0;
            cdb_source_q <= '0;
            conflicts_q  <= '0;
            tag_error_q  <= 1'b0;
            ptr_q        <= '0;
        end else begin
            xmit_q       <= xmit_d;
            cdb_write_q  <= cdb_write_d;
            cdb_data_q   <= cdb_data_d;
            cdb_source_q <= cdb_source_d;
            conflicts_q  <= conflicts_d;
            tag_error_q  <= tag_error_d;
            ptr_q        <= ptr_d;
        end
    end

    assign bus.xmit       = xmit_q;
    assign bus.CDB_write  = cdb_write_q;
    assign bus.CDB_data   = cdb_data_q;
    assign bus.CDB_source = cdb_source_q;
    assign bus.conflicts  = conflicts_q;
    assign bus.tag_error  = tag_error_q;

endmodule
